// File: rtl/float_addsub_arbiter_if.sv
// rtl/float_addsub_arbiter_if.sv - requester, response and float-unit signal bundle
interface float_addsub_arbiter_if #(
    parameter int BITS = 32,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*BITS-1:0] req_a;
    logic [NREQ*BITS-1:0] req_b;
    logic [NREQ-1:0]      req_op;
    logic [NREQ-1:0]      resp_valid;
    logic [NREQ-1:0]      resp_ready;
    logic [BITS-1:0]      resp_data;
    logic                 resp_err;
    logic                 fu_start;
    logic [BITS-1:0]      fu_a;
    logic [BITS-1:0]      fu_b;
    logic                 fu_done;
    logic [BITS-1:0]      fu_c;

    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready, fu_done, fu_c,
        input  req_ready, resp_valid, resp_data, resp_err, fu_start, fu_a, fu_b
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready, fu_done, fu_c,
        output req_ready, resp_valid, resp_data, resp_err, fu_start, fu_a, fu_b
    );
endinterface

// File: rtl/float_addsub_arbiter.sv
// rtl/float_addsub_arbiter.sv - round-robin arbiter sharing one float add unit among NREQ requesters
module float_addsub_arbiter #(
    parameter int BITS      = 32,
    parameter int EXP_WIDTH = 8,
    parameter int NREQ      = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    float_addsub_arbiter_if.slave bus
);
    localparam int TW        = $clog2(NREQ);
    localparam int CW        = $clog2(TIMEOUT) + 1;
    localparam int MAN_WIDTH = BITS - 1 - EXP_WIDTH;
    localparam int SIGN_BIT  = EXP_WIDTH + MAN_WIDTH;

    typedef enum logic [2:0] {IDLE, GRANT, ISSUE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   last_q, last_d;
    logic [TW-1:0]   tag_q, tag_d;
    logic [NREQ-1:0] req_ready_q, req_ready_d;
    logic [NREQ-1:0] resp_valid_q, resp_valid_d;
    logic [BITS-1:0] resp_data_q, resp_data_d;
    logic            resp_err_q, resp_err_d;
    logic            fu_start_q, fu_start_d;
    logic [BITS-1:0] fu_a_q, fu_a_d;
    logic [BITS-1:0] fu_b_q, fu_b_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [TW-1:0]   winner;
    logic [TW-1:0]   idx;
    logic            found;

    // Round-robin search starting just after the previous winner
    always_comb begin
        winner = last_q;
        idx    = last_q;
        found  = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = TW'((int'(last_q) + i) % NREQ);
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        tag_d        = tag_q;
        req_ready_d  = '0;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        fu_start_d   = 1'b0;
        fu_a_d       = fu_a_q;
        fu_b_d       = fu_b_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = GRANT;
                    tag_d       = winner;
                    last_d      = winner;
                    req_ready_d = NREQ'(1) << winner;
                end
            end
            GRANT: begin
                // Subtract is add with the sign of b flipped
                fu_a_d     = bus.req_a[int'(tag_q)*BITS +: BITS];
                fu_b_d     = bus.req_b[int'(tag_q)*BITS +: BITS]
                             ^ (BITS'(bus.req_op[tag_q]) << SIGN_BIT);
                fu_start_d = 1'b1;
                state_d    = ISSUE;
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.fu_done) begin
                    resp_data_d  = bus.fu_c;
                    resp_err_d   = 1'b0;
                    resp_valid_d = NREQ'(1) << tag_q;
                    state_d      = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    resp_data_d  = '0;
                    resp_err_d   = 1'b1;
                    resp_valid_d = NREQ'(1) << tag_q;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready[tag_q]) begin
                    resp_valid_d = '0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_q       <= TW'(NREQ - 1);
            tag_q        <= '0;
            req_ready_q  <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            fu_start_q   <= 1'b0;
            fu_a_q       <= '0;
            fu_b_q       <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            tag_q        <= tag_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            fu_start_q   <= fu_start_d;
            fu_a_q       <= fu_a_d;
            fu_b_q       <= fu_b_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.fu_start   = fu_start_q;
    assign bus.fu_a       = fu_a_q;
    assign bus.fu_b       = fu_b_q;
endmodule

// File: tb/tb_float_addsub_arbiter.sv
// tb/tb_float_addsub_arbiter.sv - directed self-checking bench for float_addsub_arbiter
module tb_float_addsub_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    float_addsub_arbiter_if #(.BITS(32), .NREQ(4)) bus ();

    float_addsub_arbiter #(.BITS(32), .EXP_WIDTH(8), .NREQ(4), .TIMEOUT(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    bit          fu_en  = 1'b1;
    int          fcnt   = 0;
    logic [31:0] ma, mb;

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (a == 32'h40400000 && b == 32'hBF800000) return 32'h40000000;
        return a + b;
    endfunction

    // Unit model: fu_done three cycles after fu_start
    always @(posedge clk) begin
        bus.fu_done <= 1'b0;
        bus.fu_c    <= '0;
        if (bus.fu_start && fu_en) begin
            fcnt <= 2;
            ma   <= bus.fu_a;
            mb   <= bus.fu_b;
        end else if (fcnt != 0) begin
            fcnt <= fcnt - 1;
            if (fcnt == 1) begin
                bus.fu_done <= 1'b1;
                bus.fu_c    <= fadd(ma, mb);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic op);
        bus.req_a[i*32 +: 32] = a;
        bus.req_b[i*32 +: 32] = b;
        bus.req_op[i]         = op;
    endtask

    task automatic wait_grant(input int eg);
        int n;
        n = 0;
        while (bus.req_ready == 4'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("grant", {60'b0, bus.req_ready}, 64'(1 << eg));
    endtask

    task automatic observe_op(input int eg, input logic [31:0] ea, input logic [31:0] eb,
                              input logic [31:0] ed, input logic ee, input int elat, input bit drop);
        int n;
        wait_grant(eg);
        if (drop) bus.req_valid = '0;
        @(negedge clk);
        chk("issue", {bus.fu_start, bus.req_ready, bus.fu_a}, {1'b1, 4'b0, ea});
        chk("fu_b", {32'b0, bus.fu_b}, {32'b0, eb});
        n = 0;
        while (bus.resp_valid == 4'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 64'(n), 64'(elat));
        chk("resp_valid", {59'b0, bus.req_ready, bus.resp_err}, {59'b0, 4'b0, ee});
        chk("resp_onehot", {60'b0, bus.resp_valid}, 64'(1 << eg));
        chk("resp_data", {32'b0, bus.resp_data}, {32'b0, ed});
    endtask

    initial begin
        int bad;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_op     = '0;
        bus.resp_ready = '1;
        #3;
        chk("rst_ctl", {56'b0, bus.req_ready, bus.resp_valid}, 64'b0);
        chk("rst_flags", {62'b0, bus.resp_err, bus.fu_start}, 64'b0);
        chk("rst_fu", {bus.fu_a, bus.fu_b}, 64'b0);
        chk("rst_data", {32'b0, bus.resp_data}, 64'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        set_req(0, 32'h3F800000, 32'h40000000, 1'b0);
        bus.req_valid = 4'b0001;
        observe_op(0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 4, 1'b1);

        set_req(2, 32'h40400000, 32'h3F800000, 1'b1);
        bus.req_valid = 4'b0100;
        observe_op(2, 32'h40400000, 32'hBF800000, 32'h40000000, 1'b0, 4, 1'b1);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 32'(i + 1), 32'(32'h100 * (i + 1)), 1'b0);
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            observe_op(k % 4, 32'(k % 4 + 1), 32'(32'h100 * (k % 4 + 1)),
                       fadd(32'(k % 4 + 1), 32'(32'h100 * (k % 4 + 1))), 1'b0, 4, k == 7);
        end

        fu_en = 1'b0;
        set_req(1, 32'h11, 32'h22, 1'b0);
        bus.req_valid = 4'b0010;
        observe_op(1, 32'h11, 32'h22, 32'h0, 1'b1, 65, 1'b1);
        fu_en = 1'b1;
        set_req(3, 32'h5, 32'h7, 1'b1);
        bus.req_valid = 4'b1000;
        observe_op(3, 32'h5, 32'h80000007, 32'h8000000C, 1'b0, 4, 1'b1);

        bus.resp_ready = 4'b1101;
        set_req(1, 32'h40400000, 32'h3F800000, 1'b1);
        bus.req_valid = 4'b0010;
        observe_op(1, 32'h40400000, 32'hBF800000, 32'h40000000, 1'b0, 4, 1'b1);
        set_req(0, 32'h3F800000, 32'h40000000, 1'b0);
        bus.req_valid = 4'b0001;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.resp_valid !== 4'b0010 || bus.resp_data !== 32'h40000000 || bus.req_ready !== 4'b0)
                bad++;
        end
        chk("bp_hold", 64'(bad), 64'(0));
        bus.resp_ready = '1;
        @(negedge clk);
        chk("bp_release", {60'b0, bus.resp_valid}, 64'b0);
        observe_op(0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 4, 1'b1);

        set_req(3, 32'h1, 32'h2, 1'b0);
        bus.req_valid = 4'b1000;
        wait_grant(3);
        bus.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctl", {56'b0, bus.req_ready, bus.resp_valid}, 64'b0);
        chk("rst_mid_fu", {bus.fu_a, bus.fu_b}, 64'b0);
        chk("rst_mid_data", {31'b0, bus.resp_err, bus.fu_start, bus.resp_data[30:0]}, 64'b0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.resp_valid !== 4'b0 || bus.req_ready !== 4'b0 || bus.fu_start !== 1'b0) bad++;
        end
        chk("stray_done", 64'(bad), 64'(0));
        for (int i = 0; i < 4; i++) set_req(i, 32'(i + 1), 32'(32'h100 * (i + 1)), 1'b0);
        bus.req_valid = 4'b1111;
        observe_op(0, 32'h1, 32'h100, 32'h101, 1'b0, 4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/float_addsub_arbiter.md
FLOAT_ADDSUB_ARBITER -- requirements
Module: float_addsub_arbiter

Interface
REQ-001 Parameter BITS, default 32, float word width (sign, exponent, mantissa).
REQ-002 Parameter EXP_WIDTH, default 8, exponent field width.
REQ-003 Parameter NREQ, default 4, number of requesters (2..8).
REQ-004 Parameter TIMEOUT, default 64, maximum cycles spent waiting for fu_done.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  NREQ  per-requester operation request.
REQ-008 req_ready  output  NREQ  one-hot acceptance pulse.
REQ-009 req_a, req_b  input  NREQ*BITS  per-requester operands; requester i occupies bits [i*BITS +: BITS].
REQ-010 req_op  input  NREQ  per-requester operation: 0 = add, 1 = subtract (a-b).
REQ-011 resp_valid  output  NREQ  one-hot result valid.
REQ-012 resp_ready  input  NREQ  per-requester result acceptance.
REQ-013 resp_data  output  BITS  result word, shared by all requesters.
REQ-014 resp_err  output  1  timeout flag, qualified by resp_valid.
REQ-015 fu_start  output  1  one-cycle start pulse to the shared float add unit.
REQ-016 fu_a, fu_b  output  BITS  operands to the unit; fu_b already carries the sign flip for subtract.
REQ-017 fu_done  input  1  one-cycle completion pulse from the unit.
REQ-018 fu_c  input  BITS  unit result, valid while fu_done=1.

Function
REQ-019 FSM states: IDLE, GRANT, ISSUE, WAIT, RESP; only one operation is in flight at any time.
REQ-020 IDLE: if any req_valid bit is set, select the winner round-robin and go to GRANT; otherwise stay in IDLE.
- The search starts at last_grant+1 mod NREQ, where last_grant resets to NREQ-1, so requester 0 wins first.
REQ-021 GRANT (one cycle):
- Assert req_ready[winner] for this cycle only.
- Latch a = req_a[winner] and b = req_b[winner]; if req_op[winner]=1, b is latched with bit BITS-1 inverted.
- Latch tag = winner and set last_grant = winner; go to ISSUE.
REQ-022 The winner is frozen from IDLE through RESP; changes on req_valid after the grant do not affect the operation in flight.
REQ-023 ISSUE (one cycle): fu_start=1, fu_a/fu_b = latched operands, clear the timeout counter, go to WAIT.
REQ-024 fu_a and fu_b hold the latched values from ISSUE until the next GRANT; they are 0 at reset.
REQ-025 WAIT handling:
- fu_done is sampled only in WAIT; the counter increments every WAIT cycle.
- On fu_done=1, capture fu_c into resp_data, set resp_err=0 and go to RESP.
- Otherwise, when the counter reaches TIMEOUT-1, set resp_data=0 and resp_err=1 and go to RESP.
- If fu_done and the timeout occur in the same cycle, fu_done wins (err=0).
REQ-026 A fu_done pulse outside WAIT is ignored.
REQ-027 RESP: resp_valid[tag]=1, with resp_data and resp_err held stable, until resp_ready[tag]=1; then go to IDLE on the next cycle.
- resp_ready bits of other requesters are ignored.
REQ-028 Latency: with a unit that pulses fu_done k cycles after fu_start and resp_ready held high, resp_valid rises k+2 cycles after req_ready.
- The minimum gap between successive grants is k+4 cycles.
REQ-029 Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0,...; no requester waits more than NREQ-1 other operations.
REQ-030 req_ready and resp_valid are always one-hot or zero, and are never asserted in the same cycle.
REQ-031 All outputs are driven from registers; there is no combinational path from any input to any output.

Reset
REQ-032 While rst_n=0, outputs are forced immediately to these values, regardless of clk:
- state=IDLE, req_ready=0, resp_valid=0, resp_data=0, resp_err=0, fu_start=0, fu_a=0, fu_b=0, last_grant=NREQ-1, counter=0.
REQ-033 Reset asserted mid-operation (GRANT, ISSUE, WAIT or RESP) abandons the operation with no response.
- Any later fu_done is ignored until the next WAIT state.
REQ-034 After rst_n deasserts, the first arbitration happens on the first rising edge at which any req_valid is set.

Verification
REQ-035 The bench shall cover these directed scenarios (unit model: fu_done 3 cycles after fu_start, fu_c = a+b):
- Single add: req 0 with a=0x3F800000 (1.0), b=0x40000000 (2.0), op=0 -> req_ready[0] once; fu_a=0x3F800000, fu_b=0x40000000; resp_valid[0] with resp_data=0x40400000, err=0, 5 cycles after the grant.
- Subtract: req 2 with a=0x40400000, b=0x3F800000, op=1 -> fu_b=0xBF800000; resp_valid[2], resp_data=0x40000000.
- Round-robin: all 4 req_valid held high for 8 operations -> grant order 0,1,2,3,0,1,2,3; each response one-hot on the matching requester.
- Timeout: unit never pulses fu_done, TIMEOUT=64 -> resp_valid with resp_err=1 and resp_data=0 exactly 64 WAIT cycles after ISSUE; the next grant proceeds normally.
- Response backpressure: resp_ready[1]=0 for 10 cycles -> resp_valid[1] and resp_data stable for those 10 cycles; no new req_ready while blocked.
- Reset in WAIT: rst_n pulsed low while waiting, then fu_done arrives -> all outputs 0 immediately; the stray fu_done is ignored; the next operation is granted to requester 0 first.
